// File: rtl/arith_divider_pkg.sv
// Shared types for the iterative restoring divider.
//
// Contents:
//   Util_Control_T         - control bundle: rising-edge clock and synchronous active-high reset
//   Arith_SignedUnsigned_T - operand interpretation select (Unsigned / Signed)
//   div_state_e            - divider FSM state encoding
package arith_divider_pkg;

   typedef struct packed {
      logic clk;  // rising-edge clock
      logic rst;  // synchronous, active-high reset
   } Util_Control_T;

   typedef enum logic {
      Unsigned = 1'b0,
      Signed   = 1'b1
   } Arith_SignedUnsigned_T;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPrep = 3'd1,
      StIter = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } div_state_e;

endpackage

// File: rtl/arith_divider_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//
// Ports:
//   rem_i     - current partial remainder (always < divisor_i)
//   q_i       - quotient/dividend shift register; its MSB feeds the remainder
//   divisor_i - divisor magnitude (non-zero)
//   rem_o     - partial remainder after this step
//   q_o       - shift register after this step, new quotient bit in the LSB
module arith_divider_step
   import arith_divider_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] q_o
);

   // Shifted remainder keeps its carry-out bit so the compare never overflows.
   logic [W:0]   rem_sh;
   logic [W-1:0] diff;
   logic         ge;

   always_comb begin
      rem_sh = {rem_i, q_i[W-1]};
      ge     = (rem_sh >= {1'b0, divisor_i});
      // When ge is set the true difference is below the divisor, so the low
      // W bits of a modular subtraction are exact.
      diff   = rem_sh[W-1:0] - divisor_i;
      rem_o  = ge ? diff : rem_sh[W-1:0];
      q_o    = {q_i[W-2:0], ge};
   end

endmodule

// File: rtl/arith_divider.sv
// Iterative restoring divider, one quotient bit per cycle, truncating
// semantics (remainder takes the sign of the dividend).
//
// Configuration macro: ARITH_DIVIDER_ABORT_EN adds the abort input, which
// returns any busy state to IDLE on the next edge without producing a result.
//
// Ports:
//   ctrl      - control bundle (clock, synchronous active-high reset)
//   sign      - Signed/Unsigned select, sampled on accept
//   in_valid  - operand pair valid
//   in_ready  - divider can accept (IDLE only)
//   abort     - (ARITH_DIVIDER_ABORT_EN only) cancel the operation in flight
//   dividend  - numerator
//   divisor   - denominator
//   out_valid - result valid, held until out_ready
//   out_ready - consumer takes the result
//   quotient  - result quotient
//   remainder - result remainder
//   div_zero  - divisor was zero, qualified by out_valid
//   busy      - any state other than IDLE
//
// W must be at least 2.
module arith_divider
   import arith_divider_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  Util_Control_T         ctrl,
   input  Arith_SignedUnsigned_T sign,
   input  logic                  in_valid,
   output logic                  in_ready,
`ifdef ARITH_DIVIDER_ABORT_EN
   input  logic                  abort,
`endif
   input  logic [W-1:0]          dividend,
   input  logic [W-1:0]          divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W-1:0]          quotient,
   output logic [W-1:0]          remainder,
   output logic                  div_zero,
   output logic                  busy
);

   localparam int unsigned CntW = $clog2(W + 1);
   localparam logic [CntW-1:0] CntInit = CntW'(W);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   logic clk;
   logic rst;

   assign clk = ctrl.clk;
   assign rst = ctrl.rst;

   div_state_e            state_q;
   logic                  in_ready_q;
   logic                  out_valid_q;
   logic                  busy_q;
   logic [W-1:0]          quotient_q;
   logic [W-1:0]          remainder_q;
   logic                  div_zero_q;

   // Datapath registers
   logic [W-1:0]          dvd_q;      // registered dividend
   logic [W-1:0]          dvs_q;      // registered divisor
   Arith_SignedUnsigned_T sign_q;
   logic [W-1:0]          dabs_q;     // divisor magnitude
   logic [W-1:0]          rem_q;      // partial remainder
   logic [W-1:0]          q_q;        // dividend shifted out / quotient shifted in
   logic [CntW-1:0]       count_q;
   logic                  neg_quo_q;
   logic                  neg_rem_q;
   logic                  dz_q;

   logic [W-1:0]          rem_d;
   logic [W-1:0]          q_d;

   // Operand magnitudes for PREP
   logic                  a_neg;
   logic                  b_neg;
   logic [W-1:0]          a_abs;
   logic [W-1:0]          b_abs;

   always_comb begin
      a_neg = (sign_q == Signed) && dvd_q[W-1];
      b_neg = (sign_q == Signed) && dvs_q[W-1];
      a_abs = a_neg ? (~dvd_q + 1'b1) : dvd_q;
      b_abs = b_neg ? (~dvs_q + 1'b1) : dvs_q;
   end

   arith_divider_step #(
      .W (W)
   ) u_step (
      .rem_i     (rem_q),
      .q_i       (q_q),
      .divisor_i (dabs_q),
      .rem_o     (rem_d),
      .q_o       (q_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         sign_q      <= Unsigned;
         dabs_q      <= '0;
         rem_q       <= '0;
         q_q         <= '0;
         count_q     <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid && in_ready_q) begin
                  dvd_q      <= dividend;
                  dvs_q      <= divisor;
                  sign_q     <= sign;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StPrep;
               end
            end

            StPrep: begin
               if (dvs_q == '0) begin
                  // Routed through FIX with no sign fix-up so that the
                  // divide-by-zero result appears two edges after accept.
                  q_q       <= '1;
                  rem_q     <= dvd_q;
                  neg_quo_q <= 1'b0;
                  neg_rem_q <= 1'b0;
                  dz_q      <= 1'b1;
                  state_q   <= StFix;
               end else begin
                  q_q       <= a_abs;
                  rem_q     <= '0;
                  dabs_q    <= b_abs;
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  dz_q      <= 1'b0;
                  count_q   <= CntInit;
                  state_q   <= StIter;
               end
            end

            StIter: begin
               rem_q   <= rem_d;
               q_q     <= q_d;
               count_q <= count_q - CntOne;
               if (count_q == CntOne) begin
                  state_q <= StFix;
               end
            end

            StFix: begin
               // MIN / -1 wraps back to MIN here with no flag.
               quotient_q  <= neg_quo_q ? (~q_q + 1'b1) : q_q;
               remainder_q <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
               div_zero_q  <= dz_q;
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end

            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= StIdle;
            end
         endcase

`ifdef ARITH_DIVIDER_ABORT_EN
         // Overrides the case above; in IDLE abort is ignored so an accept wins.
         if (abort && (state_q != StIdle)) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
         end
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_arith_divider.sv
// Directed self-checking bench for arith_divider at W=8.
module tb_arith_divider;
   import arith_divider_pkg::*;

   localparam int unsigned W = 8;

   logic                  clk;
   logic                  rst;
   Util_Control_T         ctrl;
   Arith_SignedUnsigned_T sign;
   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          dividend;
   logic [W-1:0]          divisor;
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          quotient;
   logic [W-1:0]          remainder;
   logic                  div_zero;
   logic                  busy;
`ifdef ARITH_DIVIDER_ABORT_EN
   logic                  abort;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   assign ctrl = '{clk: clk, rst: rst};

   arith_divider #(
      .W (W)
   ) dut (
      .ctrl      (ctrl),
      .sign      (sign),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef ARITH_DIVIDER_ABORT_EN
      .abort     (abort),
`endif
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request; returns just after the accepting edge.
   task automatic start(input Arith_SignedUnsigned_T s, input logic [7:0] a,
                        input logic [7:0] b);
      sign     = s;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Called just after the accepting edge; counts edges until out_valid.
   task automatic wait_done(input string tag, input int exp_lat, input logic [7:0] eq,
                            input logic [7:0] er, input logic edz);
      int k = 0;
      while (!out_valid && k < 40) begin
         tick();
         k++;
      end
      check({tag, "_lat"}, 32'(k), 32'(exp_lat));
      check({tag, "_quo"}, 32'(quotient), 32'(eq));
      check({tag, "_rem"}, 32'(remainder), 32'(er));
      check({tag, "_dz"}, 32'(div_zero), 32'(edz));
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_rel_ovalid"}, 32'(out_valid), 32'd0);
      check({tag, "_rel_iready"}, 32'(in_ready), 32'd1);
   endtask

   // Watches n cycles and counts any out_valid that appears.
   task automatic watch_quiet(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check({tag, "_no_result"}, 32'(seen), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      sign      = Unsigned;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b0;
`ifdef ARITH_DIVIDER_ABORT_EN
      abort     = 1'b0;
`endif
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_quo", 32'(quotient), 32'd0);
      check("rst_rem", 32'(remainder), 32'd0);
      check("rst_dz", 32'(div_zero), 32'd0);
      rst = 1'b0;
      tick();

      // 200 / 7 = 28 r 4
      start(Unsigned, 8'd200, 8'd7);
      check("u200_busy", 32'(busy), 32'd1);
      check("u200_iready", 32'(in_ready), 32'd0);
      wait_done("u200", 10, 8'd28, 8'd4, 1'b0);
      release_out("u200");

      // -7 / 2 = -3 r -1
      start(Signed, 8'hF9, 8'h02);
      wait_done("s_m7_2", 10, 8'hFD, 8'hFF, 1'b0);
      release_out("s_m7_2");

      // 7 / -2 = -3 r 1
      start(Signed, 8'h07, 8'hFE);
      wait_done("s_7_m2", 10, 8'hFD, 8'h01, 1'b0);
      release_out("s_7_m2");

      // Unsigned ignores the MSB: 249 / 2 = 124 r 1
      start(Unsigned, 8'hF9, 8'h02);
      wait_done("u249_2", 10, 8'h7C, 8'h01, 1'b0);
      release_out("u249_2");

      // MIN / -1 wraps to MIN r 0
      start(Signed, 8'h80, 8'hFF);
      wait_done("s_min_m1", 10, 8'h80, 8'h00, 1'b0);
      release_out("s_min_m1");

      // Divide by zero: all-ones quotient, dividend as remainder
      start(Signed, 8'h80, 8'h00);
      wait_done("s_dz", 2, 8'hFF, 8'h80, 1'b1);
      release_out("s_dz");

      // Backpressure: 100 / 9 = 11 r 1, held for 5 cycles
      start(Unsigned, 8'd100, 8'd9);
      wait_done("bp", 10, 8'd11, 8'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_ovalid", 32'(out_valid), 32'd1);
         check("bp_hold_quo", 32'(quotient), 32'd11);
         check("bp_hold_rem", 32'(remainder), 32'd1);
         check("bp_hold_iready", 32'(in_ready), 32'd0);
      end
      // Second request offered together with out_ready: not taken on this edge.
      sign      = Unsigned;
      dividend  = 8'd9;
      divisor   = 8'd3;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_hs_ovalid", 32'(out_valid), 32'd0);
      check("bp_hs_iready", 32'(in_ready), 32'd1);
      check("bp_hs_busy", 32'(busy), 32'd0);
      tick();
      in_valid = 1'b0;
      check("bp2_accept_busy", 32'(busy), 32'd1);
      check("bp2_accept_iready", 32'(in_ready), 32'd0);
      wait_done("bp2", 10, 8'd3, 8'd0, 1'b0);
      release_out("bp2");

      // Reset mid-ITER: five edges after accept the counter holds 4.
      start(Unsigned, 8'd200, 8'd7);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_iready", 32'(in_ready), 32'd1);
      check("mrst_ovalid", 32'(out_valid), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_quo", 32'(quotient), 32'd0);
      watch_quiet("mrst", 15);
      start(Unsigned, 8'd9, 8'd3);
      wait_done("post_rst", 10, 8'd3, 8'd0, 1'b0);
      release_out("post_rst");

`ifdef ARITH_DIVIDER_ABORT_EN
      // Abort during ITER returns to IDLE on the next edge.
      start(Unsigned, 8'd200, 8'd7);
      for (int i = 0; i < 3; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_iready", 32'(in_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ovalid", 32'(out_valid), 32'd0);
      watch_quiet("abort", 15);
      start(Unsigned, 8'd100, 8'd10);
      wait_done("post_abort", 10, 8'd10, 8'd0, 1'b0);
      release_out("post_abort");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
